// File: rtl/td4_pkg.sv
// Shared TD4 definitions: loader FSM states, default widths and opcode constants.
package td4_pkg;

    localparam int unsigned TD4_ADDR_W = 4;
    localparam int unsigned TD4_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    // Upper nibble of a TD4 instruction; lower nibble is the immediate.
    localparam logic [3:0] ADD_A_IMM = 4'b0000;
    localparam logic [3:0] OUT_IMM   = 4'b1011;
    localparam logic [3:0] JNC       = 4'b1110;
    localparam logic [3:0] JMP       = 4'b1111;

endpackage

// File: rtl/prog_rom_loader_fsm.sv
// Load-session control: state register, write pointer, beat count/checksum, handshake.
module prog_rom_loader_fsm
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = TD4_ADDR_W,
    parameter int unsigned DATA_W = TD4_DATA_W,
    parameter int unsigned SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_stall,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [SUM_W-1:0]  ld_sum,
    output logic              wr_en_c,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(1) << ADDR_W;

    ld_state_e         state;
    logic [CNT_W-1:0]  count_nxt;

    assign count_nxt = ld_count + CNT_W'(1);
    assign wr_en_c   = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            ld_count  <= '0;
            ld_sum    <= '0;
            ld_ready  <= 1'b0;
            cpu_stall <= 1'b0;
            ld_done   <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        wr_addr   <= ld_base;
                        ld_count  <= '0;
                        ld_sum    <= '0;
                        ld_ready  <= 1'b1;
                        cpu_stall <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        ld_count <= count_nxt;
                        ld_sum   <= ld_sum + SUM_W'(ld_data);
                        // Stop after DEPTH beats so a wrapped session never overwrites itself.
                        if (ld_last || count_nxt == DEPTH_CNT) begin
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ld_ready  <= 1'b0;
                    cpu_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_rom_loader.sv
// Writable program store: flop array with combinational CPU read, filled by a byte-stream loader.
module prog_rom_loader
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = TD4_ADDR_W,
    parameter int unsigned DATA_W = TD4_DATA_W,
    parameter int unsigned SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [SUM_W-1:0]  ld_sum
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr;

    prog_rom_loader_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_stall (cpu_stall),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .ld_sum    (ld_sum),
        .wr_en_c   (wr_en_c),
        .wr_addr   (wr_addr)
    );

    // Reset clears the whole image so an aborted load leaves no partial program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem[wr_addr] <= ld_data;
        end
    end

    assign cpu_data = mem[cpu_addr];

endmodule

// File: tb/tb_prog_rom_loader.sv
// Self-checking bench for prog_rom_loader: session-level reference model plus directed literal checks.
module tb_prog_rom_loader;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_data;
    logic       cpu_stall;
    logic       ld_start = 1'b0;
    logic [3:0] ld_base = '0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] ld_data = '0;
    logic       ld_last = 1'b0;
    logic       ld_done;
    logic [4:0] ld_count;
    logic [7:0] ld_sum;

    int checks = 0;
    int failures = 0;

    prog_rom_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_stall (cpu_stall),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .ld_sum    (ld_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: session open/closing flags, a shadow image and running totals.
    logic [7:0] m_mem [16];
    bit         m_loading = 0;
    bit         m_closing = 0;
    int         m_wp = 0;
    int         m_cnt = 0;
    int         m_sum = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_loading = 0;
            m_closing = 0;
            m_wp = 0;
            m_cnt = 0;
            m_sum = 0;
        end else begin
            bit was_closing;
            was_closing = m_closing;
            m_closing = 0;
            if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_wp] = ld_data;
                    m_wp = (m_wp + 1) % 16;
                    m_cnt = m_cnt + 1;
                    m_sum = (m_sum + int'(ld_data)) % 256;
                    if (ld_last || m_cnt == 16) begin
                        m_loading = 0;
                        m_closing = 1;
                    end
                end
            end else if (!was_closing && ld_start) begin
                m_loading = 1;
                m_wp = int'(ld_base);
                m_cnt = 0;
                m_sum = 0;
            end
        end
    end

    int done_pulses = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(m_loading || m_closing));
            chk("ld_ready", 32'(ld_ready), 32'(m_loading));
            chk("ld_done", 32'(ld_done), 32'(m_closing));
            chk("ld_count", 32'(ld_count), 32'(m_cnt));
            chk("ld_sum", 32'(ld_sum), 32'(m_sum));
            chk("cpu_data", 32'(cpu_data), 32'(m_mem[cpu_addr]));
            if (ld_done) done_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [3:0] base);
        ld_start = 1'b1;
        ld_base = base;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data = d;
        ld_last = last;
        tick();
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (ld_done) seen = 1;
            else tick();
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        chk(name, 32'(cpu_data), 32'(exp));
    endtask

    logic [7:0] image [16];

    initial begin
        image = '{{OUT_IMM, 4'h7}, {ADD_A_IMM, 4'h1}, {JNC, 4'h1}, {ADD_A_IMM, 4'h1},
                  {JNC, 4'h3}, {OUT_IMM, 4'h6}, {ADD_A_IMM, 4'h1}, {JNC, 4'h6},
                  {ADD_A_IMM, 4'h1}, {JNC, 4'h8}, {OUT_IMM, 4'h0}, {OUT_IMM, 4'h4},
                  {ADD_A_IMM, 4'h1}, {JNC, 4'hA}, {OUT_IMM, 4'h8}, {JMP, 4'hF}};

        // Reset then read back an empty image.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) rd("reset_mem", 4'(a), 8'h00);
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_ready", 32'(ld_ready), 32'd0);
        chk("reset_count", 32'(ld_count), 32'd0);

        // Full program image from base 0.
        done_pulses = 0;
        start(4'd0);
        for (int i = 0; i < 16; i++) beat(image[i], i == 15);
        wait_done("full_done");
        tick();
        tick();
        chk("full_done_pulses", 32'(done_pulses), 32'd1);
        chk("full_count", 32'(ld_count), 32'd16);
        chk("full_sum", 32'(ld_sum), 32'h09);
        chk("full_stall_low", 32'(cpu_stall), 32'd0);
        for (int a = 0; a < 16; a++) rd("full_mem", 4'(a), image[a]);
        rd("full_mem0_lit", 4'd0, 8'hB7);
        rd("full_mem15_lit", 4'd15, 8'hFF);

        // Wrap from base 14 with auto-stop at 16 beats, then an extra valid beat.
        start(4'd14);
        for (int i = 0; i < 16; i++) beat(8'(8'h10 + i), 1'b0);
        wait_done("wrap_done");
        ld_valid = 1'b1;
        ld_data = 8'h99;
        chk("wrap_no_ready", 32'(ld_ready), 32'd0);
        tick();
        tick();
        ld_valid = 1'b0;
        chk("wrap_count", 32'(ld_count), 32'd16);
        chk("wrap_sum", 32'(ld_sum), 32'h78);
        rd("wrap_mem14", 4'd14, 8'h10);
        rd("wrap_mem15", 4'd15, 8'h11);
        rd("wrap_mem0", 4'd0, 8'h12);
        rd("wrap_mem13", 4'd13, 8'h1F);

        // Gapped valid with early last from base 3.
        start(4'd3);
        beat(8'hAA, 1'b0);
        tick();
        tick();
        tick();
        beat(8'h55, 1'b1);
        wait_done("gap_done");
        tick();
        chk("gap_count", 32'(ld_count), 32'd2);
        chk("gap_sum", 32'(ld_sum), 32'hFF);
        rd("gap_mem3", 4'd3, 8'hAA);
        rd("gap_mem4", 4'd4, 8'h55);
        rd("gap_mem5", 4'd5, 8'h17);
        rd("gap_mem2", 4'd2, 8'h14);

        // Start plus beat while idle: only the start takes effect.
        ld_valid = 1'b1;
        ld_data = 8'hA1;
        start(4'd0);
        ld_valid = 1'b0;
        rd("start_beat_dropped", 4'd0, 8'h12);
        beat(8'hA1, 1'b0);
        // Restart attempt mid-session is ignored.
        ld_start = 1'b1;
        ld_base = 4'd9;
        beat(8'hA2, 1'b0);
        ld_start = 1'b0;
        chk("restart_count", 32'(ld_count), 32'd2);
        beat(8'hA3, 1'b1);
        wait_done("restart_done");
        tick();
        chk("restart_final_count", 32'(ld_count), 32'd3);
        rd("restart_mem0", 4'd0, 8'hA1);
        rd("restart_mem1", 4'd1, 8'hA2);
        rd("restart_mem2", 4'd2, 8'hA3);
        rd("restart_mem9", 4'd9, 8'h1B);

        // Asynchronous reset in the middle of a session.
        start(4'd6);
        for (int i = 0; i < 5; i++) beat(8'(8'h60 + i), 1'b0);
        cpu_addr = 4'd6;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(cpu_stall), 32'd0);
        chk("arst_ready", 32'(ld_ready), 32'd0);
        chk("arst_count", 32'(ld_count), 32'd0);
        chk("arst_sum", 32'(ld_sum), 32'd0);
        chk("arst_data", 32'(cpu_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) rd("arst_mem", 4'(a), 8'h00);
        tick();
        chk("arst_idle_ready", 32'(ld_ready), 32'd0);
        chk("arst_idle_done", 32'(ld_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
Parametrised, writable successor to the fixed 16x8 instruction ROM. It holds the CPU program in a flop array and keeps the same combinational CPU read path. The array is filled at run time through a valid/ready byte-stream loader instead of a hard-coded case table. It sits between the CPU fetch path and a host/UART loader, and halts the CPU while a load is in progress.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
DATA_W, 8, instruction word width
SUM_W, 8, width of running checksum (modulo 2**SUM_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  CPU fetch address (PC)
cpu_data  out  DATA_W  instruction at cpu_addr, combinational read
cpu_stall  out  1  high while loader owns memory; CPU must hold PC
ld_start  in  1  single-cycle request to begin a load session
ld_base  in  ADDR_W  first write address, sampled with ld_start
ld_valid  in  1  beat valid
ld_ready  out  1  loader can accept a beat
ld_data  in  DATA_W  beat payload
ld_last  in  1  marks final beat of the session (qualified by valid&ready)
ld_done  out  1  one-cycle pulse at session end
ld_count  out  ADDR_W+1  beats written in current/last session
ld_sum  out  SUM_W  modulo sum of beats written in current/last session

Behaviour:
- Reset (async, rst_n=0): all DEPTH words = 0; state IDLE; cpu_stall=0, ld_ready=0, ld_done=0, ld_count=0, ld_sum=0; write pointer=0. Reset mid-session aborts the session; partial contents are lost (cleared to 0).
- cpu_data = mem[cpu_addr] at all times, zero-latency combinational. A word written at edge N is visible on cpu_data from edge N onward.
- FSM states: IDLE, LOAD, DONE.
- IDLE: ld_ready=0, cpu_stall=0. ld_start=1 at an edge -> LOAD; wptr<=ld_base, ld_count<=0, ld_sum<=0.
- LOAD: ld_ready=1, cpu_stall=1. Beat accepted on edge where ld_valid&&ld_ready: mem[wptr]<=ld_data; wptr<=wptr+1 modulo DEPTH (wraps DEPTH-1 -> 0); ld_count+=1; ld_sum+=ld_data (truncate to SUM_W, zero-extend data if DATA_W<SUM_W).
- LOAD exits to DONE on an accepted beat when ld_last=1 or the post-increment ld_count==DEPTH. Auto-stop at DEPTH beats prevents overwriting the session's own data after wrap. ld_valid without ld_ready never occurs in LOAD; valid is ignored in IDLE/DONE.
- DONE: exactly one cycle. ld_done=1, ld_ready=0, cpu_stall=1. Then -> IDLE.
- ld_start in LOAD or DONE is ignored (no restart). ld_start and a beat in the same cycle while IDLE: only the start takes effect; that beat is not written.
- ld_count/ld_sum hold their final values in IDLE until the next ld_start.
- All outputs except cpu_data are registered or decoded from the state register only; no combinational input-to-output path besides cpu_addr->cpu_data.

Decomposition:
- Shared package td4_pkg: state enum {IDLE, LOAD, DONE}; TD4 opcode constants (ADD_A_IMM, JNC, OUT_IMM, JMP) for benches and default images; default ADDR_W/DATA_W.
- One natural sub-module: prog_rom_loader_fsm (state register, wptr, count/sum, handshake decode). The top holds the flop array and the read mux.

Test Plan:
- Reset then read: rst_n low 2 cycles, release; sweep cpu_addr 0..15 -> cpu_data=0x00 every address, cpu_stall=0, ld_ready=0.
- Full image load: ld_start, ld_base=0; 16 beats of the TD4 program (0xB7,0x01,0xE1,...,0xFF) with ld_last on beat 16 -> ld_done pulses once; ld_count=16; ld_sum = byte sum mod 256; cpu_data matches every word; cpu_stall low after DONE.
- Wrap and auto-stop: ld_base=14; 16 beats 0x10..0x1F, ld_last never asserted -> mem[14]=0x10, mem[15]=0x11, mem[0]=0x12 ... mem[13]=0x1F; ld_done after beat 16; a 17th valid beat is not accepted (ld_ready=0).
- Gapped valid and early last: ld_base=3; beats 0xAA, idle 3 cycles, then 0x55 with ld_last -> mem[3]=0xAA, mem[4]=0x55, other words unchanged; ld_count=2, ld_sum=0xFF.
- Ignored restart: during LOAD, pulse ld_start with ld_base=9 -> wptr continues sequentially from original base; ld_count is not cleared.
- Reset mid-load: after 5 beats, assert rst_n low asynchronously between edges -> outputs go to reset values immediately; all words read 0; state IDLE.
